// File: rtl/alu_exec_unit.sv
// RISC-V execute stage: single-cycle RV32I ALU plus iterative RV32M multiply/divide,
// with valid/ready handshakes on both the request and result sides.
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [6:0]      opcode,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic [1:0]      dbg_state_o
);

   localparam int SW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Handshake: a request is taken on a rising edge where in_valid && in_ready;
   // a result is consumed on a rising edge where out_valid && out_ready.
   state_e          state_q;
   logic            out_valid_q;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   logic            illegal_q;
   logic [SW-1:0]   cnt_q;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] opnd_q;
   logic            neg_q;
   logic            sel_q;

   logic accept;
   assign in_ready    = rst && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
   assign accept      = in_valid && in_ready;
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign zero        = zero_q;
   assign illegal     = illegal_q;
   assign dbg_state_o = state_q;

   // ---------------- decode and single-cycle datapath ----------------
   logic            is_rtype;
   logic            is_m;
   logic [SW-1:0]   shamt;
   logic            div_by_zero;
   logic            div_ovf;
   logic [XLEN-1:0] alu_res_d;
   logic            alu_ill_d;
   logic            go_mul_d;
   logic            go_div_d;

   assign is_rtype    = (opcode == 7'b0110011);
   assign is_m        = (alu_op == 3'b010) && is_rtype && (funct7 == 7'b0000001);
   assign shamt       = op_b[SW-1:0];
   assign div_by_zero = (op_b == '0);
   assign div_ovf     = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

   always_comb begin
      alu_res_d = '0;
      alu_ill_d = 1'b0;
      go_mul_d  = 1'b0;
      go_div_d  = 1'b0;
      case (alu_op)
         3'b000: alu_res_d = op_a + op_b;
         3'b001: alu_res_d = op_a - op_b;
         3'b011: alu_res_d = op_b;
         3'b010: begin
            if (is_m) begin
               if (!ENABLE_M)          alu_ill_d = 1'b1;
               else if (!funct3[2])    go_mul_d  = 1'b1;
               // Divide corner cases never enter the iterative loop.
               else if (div_by_zero)   alu_res_d = funct3[1] ? op_a : '1;
               else if (div_ovf)       alu_res_d = funct3[1] ? '0 : op_a;
               else                    go_div_d  = 1'b1;
            end else begin
               case (funct3)
                  3'b000: alu_res_d = (is_rtype && funct7 == 7'b0100000) ? op_a - op_b : op_a + op_b;
                  3'b001: alu_res_d = op_a << shamt;
                  3'b010: alu_res_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                  3'b011: alu_res_d = {{(XLEN-1){1'b0}}, op_a < op_b};
                  3'b100: alu_res_d = op_a ^ op_b;
                  3'b101: alu_res_d = funct7[5] ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
                  3'b110: alu_res_d = op_a | op_b;
                  default: alu_res_d = op_a & op_b;
               endcase
            end
         end
         default: alu_ill_d = 1'b1;
      endcase
   end

   // ---------------- iterative operand setup ----------------
   logic            a_sgn;
   logic            b_sgn;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic            neg_d;
   logic            sel_d;

   assign a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
   assign b_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
   assign a_neg = a_sgn && op_a[XLEN-1];
   assign b_neg = b_sgn && op_b[XLEN-1];
   assign a_abs = a_neg ? -op_a : op_a;
   assign b_abs = b_neg ? -op_b : op_b;
   // Remainder follows the dividend's sign; everything else the product of signs.
   assign neg_d = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
   // Multiply: select upper half; divide: select remainder.
   assign sel_d = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);

   // ---------------- multiply / divide step ----------------
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   mul_acc_d;
   logic [XLEN-1:0]   mul_lo_d;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [XLEN-1:0]   div_rem_d;
   logic [XLEN-1:0]   div_quo_d;
   logic [XLEN-1:0]   div_sel;
   logic [XLEN-1:0]   fin_d;

   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign mul_acc_d = mul_sum[XLEN:1];
   assign mul_lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
   assign prod      = {mul_acc_d, mul_lo_d};
   assign prod_s    = neg_q ? -prod : prod;

   assign div_shift = {acc_q, lo_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_diff  = div_shift[XLEN-1:0] - opnd_q;
   assign div_rem_d = div_ge ? div_diff : div_shift[XLEN-1:0];
   assign div_quo_d = {lo_q[XLEN-2:0], div_ge};
   assign div_sel   = sel_q ? div_rem_d : div_quo_d;

   always_comb begin
      fin_d = '0;
      if (state_q == S_MUL) fin_d = sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      else                  fin_d = neg_q ? -div_sel : div_sel;
   end

   // ---------------- control FSM with registered outputs ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         neg_q       <= 1'b0;
         sel_q       <= 1'b0;
      end else if (accept) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         lo_q   <= go_mul_d ? b_abs : a_abs;
         opnd_q <= go_mul_d ? a_abs : b_abs;
         neg_q  <= neg_d;
         sel_q  <= sel_d;
         if (go_mul_d) begin
            state_q     <= S_MUL;
            out_valid_q <= 1'b0;
         end else if (go_div_d) begin
            state_q     <= S_DIV;
            out_valid_q <= 1'b0;
         end else begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            zero_q      <= (alu_res_d == '0);
            illegal_q   <= alu_ill_d;
         end
      end else begin
         case (state_q)
            S_MUL, S_DIV: begin
               cnt_q <= cnt_q + 1'b1;
               acc_q <= (state_q == S_MUL) ? mul_acc_d : div_rem_d;
               lo_q  <= (state_q == S_MUL) ? mul_lo_d : div_quo_d;
               if (cnt_q == SW'(XLEN-1)) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin_d;
                  zero_q      <= (fin_d == '0);
                  illegal_q   <= 1'b0;
                  cnt_q       <= '0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a scoreboard queue, then
// backpressure, reset-abort and ENABLE_M=0 sequences.
module tb_alu_exec_unit;

   localparam int XLEN = 32;
   localparam logic [6:0] R_OP = 7'b0110011;
   localparam logic [6:0] I_OP = 7'b0010011;
   localparam logic [6:0] F7_0 = 7'b0000000;
   localparam logic [6:0] F7_S = 7'b0100000;
   localparam logic [6:0] F7_M = 7'b0000001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            in_valid = 1'b0, out_ready = 1'b0;
   logic [2:0]      alu_op = '0, funct3 = '0;
   logic [6:0]      funct7 = '0, opcode = '0;
   logic [XLEN-1:0] op_a = '0, op_b = '0;
   logic            in_ready, out_valid, zero, illegal;
   logic [XLEN-1:0] result;
   logic [1:0]      dbg_state;

   logic            nm_in_valid = 1'b0, nm_out_ready = 1'b0;
   logic [2:0]      nm_alu_op = '0, nm_funct3 = '0;
   logic [6:0]      nm_funct7 = '0, nm_opcode = '0;
   logic [XLEN-1:0] nm_op_a = '0, nm_op_b = '0;
   logic            nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
   logic [XLEN-1:0] nm_result;
   logic [1:0]      nm_dbg_state;

   alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .opcode(opcode),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal), .dbg_state_o(dbg_state)
   );

   alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
      .alu_op(nm_alu_op), .funct3(nm_funct3), .funct7(nm_funct7), .opcode(nm_opcode),
      .op_a(nm_op_a), .op_b(nm_op_b), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
      .result(nm_result), .zero(nm_zero), .illegal(nm_illegal), .dbg_state_o(nm_dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [XLEN:0] exp_q[$];   // {illegal, result}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name);
      logic [XLEN:0] e;
      if (exp_q.size() == 0) begin
         check({name, " queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check({name, " result"}, 64'(result), 64'(e[XLEN-1:0]));
         check({name, " illegal"}, 64'(illegal), 64'(e[XLEN]));
         check({name, " zero"}, 64'(zero), 64'(e[XLEN-1:0] == '0));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string           name;
      logic [2:0]      op;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [6:0]      opc;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
      logic            ill;
      int              lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [2:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [6:0] opc,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] res, input logic ill, input int lat);
      vec_t v;
      v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.opc = opc;
      v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic do_op(input vec_t v);
      int guard;
      int lat;
      bit busy_ready;
      @(negedge clk);
      alu_op = v.op; funct3 = v.f3; funct7 = v.f7; opcode = v.opc;
      op_a = v.a; op_b = v.b; in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check({v.name, " in_ready"}, 64'(in_ready), 64'd1);
      exp_q.push_back({v.ill, v.res});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs after accept: the captured request must be unaffected.
      op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
      lat = 1;
      busy_ready = 1'b0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, 64'(lat), 64'(v.lat));
      check({v.name, " busy in_ready"}, 64'(busy_ready), 64'd0);
      check_out(v.name);
   endtask

   task automatic nm_op(input string name, input logic [2:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] eres, input logic eill);
      @(negedge clk);
      nm_alu_op = op; nm_funct3 = f3; nm_funct7 = f7; nm_opcode = R_OP;
      nm_op_a = a; nm_op_b = b; nm_in_valid = 1'b1; nm_out_ready = 1'b1;
      check({name, " in_ready"}, 64'(nm_in_ready), 64'd1);
      @(posedge clk);
      #1;
      nm_in_valid = 1'b0;
      @(negedge clk);
      check({name, " out_valid"}, 64'(nm_out_valid), 64'd1);
      check({name, " result"}, 64'(nm_result), 64'(eres));
      check({name, " illegal"}, 64'(nm_illegal), 64'(eill));
   endtask

   // ---------------- test ----------------
   initial begin
      vecs.push_back(mk("sub_rtype",  3'b010, 3'b000, F7_S, R_OP, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1));
      vecs.push_back(mk("sra",        3'b010, 3'b101, F7_S, R_OP, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1));
      vecs.push_back(mk("srl",        3'b010, 3'b101, F7_0, R_OP, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1));
      vecs.push_back(mk("sltu",       3'b010, 3'b011, F7_0, R_OP, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1));
      vecs.push_back(mk("slt",        3'b010, 3'b010, F7_0, R_OP, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1));
      vecs.push_back(mk("sll_mask",   3'b010, 3'b001, F7_0, R_OP, 32'd1, 32'h0000003F, 32'h80000000, 1'b0, 1));
      vecs.push_back(mk("xor",        3'b010, 3'b100, F7_0, R_OP, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1));
      vecs.push_back(mk("or",         3'b010, 3'b110, F7_0, R_OP, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1));
      vecs.push_back(mk("and",        3'b010, 3'b111, F7_0, R_OP, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1));
      vecs.push_back(mk("addi_f7s",   3'b010, 3'b000, F7_S, I_OP, 32'd5, 32'd7, 32'd12, 1'b0, 1));
      vecs.push_back(mk("addi_f7m",   3'b010, 3'b000, F7_M, I_OP, 32'd5, 32'd7, 32'd12, 1'b0, 1));
      vecs.push_back(mk("add_wrap",   3'b000, 3'b000, F7_0, R_OP, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1));
      vecs.push_back(mk("sub_op",     3'b001, 3'b000, F7_0, R_OP, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1));
      vecs.push_back(mk("pass_b",     3'b011, 3'b000, F7_0, R_OP, 32'd9, 32'h12345000, 32'h12345000, 1'b0, 1));
      vecs.push_back(mk("illegal_op", 3'b101, 3'b000, F7_0, R_OP, 32'd9, 32'd9, 32'd0, 1'b1, 1));
      vecs.push_back(mk("mulh",       3'b010, 3'b001, F7_M, R_OP, 32'hFFFFFFFD, 32'h40000000, 32'hFFFFFFFF, 1'b0, 33));
      vecs.push_back(mk("mulhu",      3'b010, 3'b011, F7_M, R_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33));
      vecs.push_back(mk("mul",        3'b010, 3'b000, F7_M, R_OP, 32'd6, 32'd7, 32'd42, 1'b0, 33));
      vecs.push_back(mk("mulhsu",     3'b010, 3'b010, F7_M, R_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33));
      vecs.push_back(mk("div",        3'b010, 3'b100, F7_M, R_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33));
      vecs.push_back(mk("rem",        3'b010, 3'b110, F7_M, R_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33));
      vecs.push_back(mk("divu",       3'b010, 3'b101, F7_M, R_OP, 32'd100, 32'd7, 32'd14, 1'b0, 33));
      vecs.push_back(mk("remu",       3'b010, 3'b111, F7_M, R_OP, 32'd100, 32'd7, 32'd2, 1'b0, 33));
      vecs.push_back(mk("divu_by0",   3'b010, 3'b101, F7_M, R_OP, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0, 1));
      vecs.push_back(mk("rem_by0",    3'b010, 3'b110, F7_M, R_OP, 32'd5, 32'd0, 32'd5, 1'b0, 1));
      vecs.push_back(mk("div_ovf",    3'b010, 3'b100, F7_M, R_OP, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1));
      vecs.push_back(mk("rem_ovf",    3'b010, 3'b110, F7_M, R_OP, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1));

      // Reset state
      #12;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst result", 64'(result), 64'd0);
      check("rst zero", 64'(zero), 64'd1);
      check("rst illegal", 64'(illegal), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd0);
      check("rst state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) do_op(vecs[i]);

      // Backpressure: hold the result for 10 cycles, then consume and accept together.
      @(negedge clk);
      alu_op = 3'b000; op_a = 32'd2; op_b = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back({1'b0, 32'd5});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp hold result", 64'(result), 64'd5);
         check("bp hold valid", 64'(out_valid), 64'd1);
         check("bp hold in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      check_out("bp first");
      alu_op = 3'b000; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("b2b in_ready", 64'(in_ready), 64'd1);
      exp_q.push_back({1'b0, 32'd30});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b out_valid", 64'(out_valid), 64'd1);
      check_out("b2b second");

      // Reset in the middle of a divide
      @(negedge clk);
      alu_op = 3'b010; funct3 = 3'b101; funct7 = F7_M; opcode = R_OP;
      op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
      #1;
      check("rdiv in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("rdiv state busy", 64'(dbg_state), 64'd2);
      rst = 1'b0;
      #1;
      check("rdiv out_valid", 64'(out_valid), 64'd0);
      check("rdiv result", 64'(result), 64'd0);
      check("rdiv zero", 64'(zero), 64'd1);
      check("rdiv in_ready", 64'(in_ready), 64'd0);
      check("rdiv state", 64'(dbg_state), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rdiv release in_ready", 64'(in_ready), 64'd1);
      do_op(mk("add_after_rst", 3'b000, 3'b000, F7_0, R_OP, 32'd1, 32'd1, 32'd2, 1'b0, 1));

      // ENABLE_M = 0 instance
      nm_op("nm_mul", 3'b010, 3'b000, F7_M, 32'd6, 32'd7, 32'd0, 1'b1);
      nm_op("nm_div", 3'b010, 3'b100, F7_M, 32'd6, 32'd3, 32'd0, 1'b1);
      nm_op("nm_pass", 3'b011, 3'b000, F7_0, 32'd1, 32'h12345000, 32'h12345000, 1'b0);

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute stage for the RISC-V core. It decodes ALUOp/funct3/funct7/opcode into an operation and executes it on XLEN-bit operands. Base RV32I ALU operations take one cycle; RV32M multiply/divide operations run iteratively over multiple cycles. Operands enter and results leave through valid/ready handshakes, so the control path can stall on long operations.

## Interface
- XLEN, 32: operand/result width, power of two, ≥8
- ENABLE_M, 1: 1 = execute RV32M ops; 0 = flag them illegal
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  3  000 add, 001 sub, 010 funct-decoded, 011 pass op_b, others illegal
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- opcode  in  7  instruction opcode; R-type = 0110011
- op_a, op_b  in  XLEN  operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  request decoded as illegal; result = 0

## Operation
- Accept occurs when in_valid && in_ready. Decode and operands are captured on accept; later input changes are ignored.
- Decode for alu_op = 010:
  - M group when opcode is R-type and funct7 = 0000001. funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Otherwise by funct3: 000 ADD, or SUB when R-type and funct7 = 0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5] = 1; 110 OR; 111 AND.
  - Shift amount is op_b[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1, zero-extended.
- Wrap-around: all arithmetic is modulo 2^XLEN. MULH* return the upper XLEN bits of the 2·XLEN product.
- Divide special cases resolve at accept and use the single-cycle path:
  - divisor 0 gives quotient all-ones and remainder = op_a.
  - signed most-negative / −1 gives quotient = op_a and remainder = 0.
- ENABLE_M = 0 with an M op, or alu_op ∈ {100..111}: illegal = 1 and result = 0, single-cycle path.
- FSM states:
  - IDLE: accept → MUL (multiply), DIV (non-special divide), or DONE (everything else, with result computed).
  - MUL: radix-2 shift-add on absolute values, one bit per cycle, XLEN cycles → DONE. The sign is applied on the final cycle.
  - DIV: restoring division on absolute values, one quotient bit per cycle, XLEN cycles → DONE. Signs are fixed on the final cycle: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - DONE: out_valid = 1. On out_ready: a new accept in the same cycle goes to the target state, otherwise → IDLE.
- in_ready = rst && (state == IDLE || (state == DONE && out_ready)).

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 1, illegal 0, iteration counter 0. in_ready is 0 while rst is low.
- Single-cycle ops: accept at edge N, out_valid high after edge N+1.
- MUL/DIV: out_valid high XLEN+1 edges after accept (33 for XLEN = 32). in_ready stays 0 throughout.
- out_valid, result, zero and illegal hold stable while out_valid && !out_ready.
- Back-to-back: a result consumed and a new request accepted in the same cycle gives zero-bubble throughput for single-cycle ops.
- Reset asserted mid-MUL/DIV aborts immediately to the reset values. No partial result is ever presented.
- out_ready is ignored while out_valid = 0.

## Test plan
- Base ALU (XLEN 32): alu_op 010, R-type, funct7 0100000, funct3 000, a = 5, b = 7 → result 0xFFFFFFFE one cycle after accept, zero 0. SRA of 0x80000000 by 4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1.
- Multiply: MULH −3 × 0x40000000 → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL 6 × 7 → 42. Each has out_valid exactly 33 edges after accept, with in_ready 0 during.
- Divide: DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 0 → 0xFFFFFFFF one cycle later; DIV 0x80000000 / −1 → 0x80000000; REM of the same → 0, zero 1.
- Backpressure: out_ready held 0 for 10 cycles after a result → result and out_valid stable and in_ready 0. Then out_ready and in_valid both 1 → new accept in the same cycle, next result one cycle later.
- Reset mid-DIV: rst low 5 cycles after accept → out_valid 0 and result 0 immediately. After release, in_ready 1 and a fresh ADD 1+1 → 2.
- ENABLE_M = 0: MUL request → illegal 1, result 0 after one cycle. alu_op 011, b = 0x12345000 → result 0x12345000, illegal 0.
